// File: rtl/led_scroller_multi.sv
// Multi-mode LED pattern engine. It steps a pattern across LED_NUM LEDs once per
// (CNT_1S >> speed) cycles. The modes are rotate left, rotate right, bounce and fill/empty bar.
module led_scroller_multi #(
  parameter int unsigned LED_NUM        = 16,
  parameter logic [26:0] CNT_1S         = 27'd100_000_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step
);

  localparam int unsigned   PosW    = $clog2(LED_NUM + 1);
  localparam logic [PosW-1:0] PosLast = PosW'(LED_NUM - 1);
  localparam logic [PosW-1:0] PosPrev = PosW'(LED_NUM - 2);
  localparam logic [PosW-1:0] PosFull = PosW'(LED_NUM);

  typedef enum logic [1:0] {
    ModeRotL   = 2'd0,
    ModeRotR   = 2'd1,
    ModeBounce = 2'd2,
    ModeFill   = 2'd3
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Raw (active-high) pattern for a mode at a given position or fill level.
  function automatic logic [LED_NUM-1:0] pattern(input mode_e m, input logic [PosW-1:0] p);
    logic [LED_NUM:0] one;
    logic [LED_NUM:0] wide;
    one = {{LED_NUM{1'b0}}, 1'b1};
    // One extra bit so a full bar (p == LED_NUM) still fits before the subtract.
    if (m == ModeFill) wide = (one << p) - one;
    else               wide = one << p;
    return wide[LED_NUM-1:0];
  endfunction

  function automatic logic [LED_NUM-1:0] polarize(input logic [LED_NUM-1:0] pat);
    return LED_ACTIVE_LOW ? ~pat : pat;
  endfunction

  logic [26:0]        cnt_q, cnt_d;
  logic [PosW-1:0]    pos_q, pos_d;
  dir_e               dir_q, dir_d;
  mode_e              mode_q, mode_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               step_q, step_d;

  logic [26:0] period;
  logic        tick;
  logic        mode_chg;

  assign period   = CNT_1S >> speed;
  // >= rather than == so a shorter period taking effect mid-count steps at once.
  assign tick     = (cnt_q >= period - 27'd1) & ~pause;
  assign mode_chg = (mode_e'(mode) != mode_q);

  // Next-state: a mode change restarts the pattern and beats a coincident tick.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (mode_chg) begin
      mode_d = mode_e'(mode);
      pos_d  = '0;
      dir_d  = DirUp;
      cnt_d  = '0;
    end else if (tick) begin
      cnt_d = '0;
      unique case (mode_q)
        ModeRotL: pos_d = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
        ModeRotR: pos_d = (pos_q == '0) ? PosLast : pos_q - 1'b1;
        ModeBounce: begin
          if (dir_q == DirUp) begin
            if (pos_q == PosLast) begin
              dir_d = DirDown;
              pos_d = PosPrev;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DirUp;
              pos_d = PosW'(1);
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        ModeFill: pos_d = (pos_q == PosFull) ? '0 : pos_q + 1'b1;
      endcase
    end else if (!pause) begin
      cnt_d = cnt_q + 27'd1;
    end
    step_d = mode_chg | tick;
    led_d  = polarize(pattern(mode_d, pos_d));
  end

  // State registers; reset loads the initial pattern of the mode currently selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DirUp;
      mode_q <= mode_e'(mode);
      led_q  <= polarize(pattern(mode_e'(mode), '0));
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_scroller_multi.sv
// Directed bench: two 8-LED instances (active-low and active-high) with CNT_1S = 100.
module tb_led_scroller_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [7:0] led_l, led_h;
  logic       step_l, step_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_scroller_multi #(
    .LED_NUM(8), .CNT_1S(27'd100), .LED_ACTIVE_LOW(1'b1)
  ) u_dut_low (
    .clk(clk), .reset(reset), .mode(mode), .speed(speed), .pause(pause),
    .led(led_l), .step(step_l)
  );

  led_scroller_multi #(
    .LED_NUM(8), .CNT_1S(27'd100), .LED_ACTIVE_LOW(1'b0)
  ) u_dut_high (
    .clk(clk), .reset(reset), .mode(mode), .speed(speed), .pause(pause),
    .led(led_h), .step(step_h)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] rotl   [8];
  logic [7:0] bounce [14];
  logic [7:0] fill   [9];
  int         bad;

  initial begin
    rotl   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    bounce = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
               8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD};
    fill   = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    reset = 1'b1; mode = 2'd0; speed = 2'd0; pause = 1'b0;
    cycles(2);
    check("rst_led_low", led_l, 8'hFE);
    check("rst_step", step_l, 1'b0);
    check("rst_led_high", led_h, 8'h01);

    // Rotate left, period 100: cnt is 0 after the last reset edge.
    reset = 1'b0;
    cycles(99);
    check("rotl_hold", led_l, 8'hFE);
    cycles(1);
    check("rotl_step1", led_l, rotl[1]);
    check("rotl_step_pulse", step_l, 1'b1);
    for (int k = 2; k <= 8; k++) begin
      cycles(100);
      check($sformatf("rotl_%0d", k), led_l, rotl[k % 8]);
    end

    // Pause at cnt = 40 for 200 cycles, then 60 more cycles to the next advance.
    cycles(40);
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (led_l !== 8'hFE || step_l !== 1'b0) bad++;
    end
    check("pause_frozen", bad, 0);
    pause = 1'b0;
    cycles(59);
    check("pause_resume_hold", led_l, 8'hFE);
    cycles(1);
    check("pause_resume_adv", led_l, 8'hFD);

    // Mode change while paused.
    pause = 1'b1; mode = 2'd1;
    cycles(1);
    check("modechg_led", led_l, 8'hFE);
    check("modechg_step", step_l, 1'b1);
    cycles(1);
    check("modechg_step_low", step_l, 1'b0);
    pause = 1'b0;
    cycles(100);
    check("rotr_wrap", led_l, 8'h7F);

    // Speed drop at cnt = 80 to period 12.
    cycles(80);
    speed = 2'd3;
    cycles(1);
    check("speed_drop_adv", led_l, 8'hBF);
    check("speed_drop_step", step_l, 1'b1);
    cycles(11);
    check("speed_hold", led_l, 8'hBF);
    cycles(1);
    check("speed_next", led_l, 8'hDF);

    // Bounce, period 25; run to pos 5 heading down.
    speed = 2'd2; mode = 2'd2;
    cycles(1);
    check("bounce_start", led_l, 8'hFE);
    for (int k = 1; k <= 23; k++) begin
      cycles(25);
      check($sformatf("bounce_%0d", k), led_l, bounce[k % 14]);
    end

    // Reset mid-step.
    cycles(10);
    reset = 1'b1; speed = 2'd0;
    cycles(1);
    check("rst_mid_led", led_l, 8'hFE);
    check("rst_mid_step", step_l, 1'b0);
    reset = 1'b0;
    cycles(99);
    check("rst_mid_hold", led_l, 8'hFE);
    cycles(1);
    check("rst_mid_adv", led_l, 8'hFD);
    cycles(100);
    check("rst_mid_dir_up", led_l, 8'hFB);

    // Fill/empty on the active-high instance, period 12.
    speed = 2'd3; mode = 2'd3;
    cycles(1);
    check("fill_start_high", led_h, 8'h00);
    check("fill_start_low", led_l, 8'hFF);
    check("fill_start_step", step_h, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cycles(12);
      check($sformatf("fill_%0d", k), led_h, fill[k % 9]);
      if (k == 4) check("fill_4_low", led_l, 8'hF0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
